// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//
// Shared definitions for the execute-stage ALU blocks:
//   alu_ctrl_t    3-bit decoded ALU control code
//   ALU_*         control code constants (ALU_MULT selects the multiplier)
//   mult_state_t  state encoding of the multi-cycle multiply sequencer
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD  = 3'b000;
  localparam alu_ctrl_t ALU_XOR  = 3'b001;
  localparam alu_ctrl_t ALU_SUB  = 3'b010;
  localparam alu_ctrl_t ALU_SLT  = 3'b011;
  localparam alu_ctrl_t ALU_SLL  = 3'b100;
  localparam alu_ctrl_t ALU_SRL  = 3'b101;
  localparam alu_ctrl_t ALU_MULT = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage : alu_pkg

// File: rtl/mult_shift_add_dp.sv
// -----------------------------------------------------------------------------
// mult_shift_add_dp
//
// Shift-add multiplier datapath: accumulator, multiplicand and multiplier
// registers plus the 2*WIDTH-bit adder. Sequencing comes from the FSM in
// alu_mult_sequencer through two enables.
//
// Optional build macro: ALU_MULT_EARLY_TERM_EN adds mplier_last_o, which
// flags that the multiplier has no set bits left after the current shift.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   load_i         capture operands, clear accumulator
//   step_i         perform one add-and-shift iteration
//   op_a_i         multiplicand (unsigned)
//   op_b_i         multiplier (unsigned)
//   acc_o          running / final product
//   mplier_last_o  (macro only) multiplier is zero after this step's shift
// -----------------------------------------------------------------------------
module mult_shift_add_dp
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     op_a_i,
  input  logic [WIDTH-1:0]     op_b_i,
  output logic [2*WIDTH-1:0]   acc_o
`ifdef ALU_MULT_EARLY_TERM_EN
  ,
  output logic                 mplier_last_o
`endif
);

  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, op_a_i};
      mplier_d = op_b_i;
    end else if (step_i) begin
      // Sum wraps modulo 2^(2*WIDTH); the final product always fits anyway.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order. All datapath
  // registers are plain flops (no memory arrays), so all of them are reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign acc_o = acc_q;

`ifdef ALU_MULT_EARLY_TERM_EN
  // After this step's right shift only bits [WIDTH-1:1] survive.
  assign mplier_last_o = (mplier_q[WIDTH-1:1] == '0);
`endif

endmodule : mult_shift_add_dp

// File: rtl/alu_mult_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mult_sequencer
//
// Execute-stage controller for a multi-cycle unsigned shift-add multiply.
// Only ALU_MULT is accepted; every other code passes through with the block
// idle and never stalling. While the multiply iterates the pipeline is held
// with stall; the product is presented with a one-cycle done pulse and then
// held on result_hi/result_lo until the next completed multiply.
//
// Optional build macro: ALU_MULT_EARLY_TERM_EN -- leave RUN as soon as the
// remaining multiplier bits are all zero (default build: fixed WIDTH
// iterations, done at accept + WIDTH + 1).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   start      execute-stage instruction valid
//   alu_ctrl   decoded ALU control code
//   op_a       multiplicand (unsigned)
//   op_b       multiplier (unsigned)
//   flush      pipeline flush, aborts a multiply in progress
//   stall      pipeline hold request (combinational)
//   busy       high in RUN or DONE
//   done       one-cycle product-valid pulse
//   result_lo  low half of the product
//   result_hi  high half of the product
// -----------------------------------------------------------------------------
module alu_mult_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  mult_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [2*WIDTH-1:0] acc;

  logic accept;
  logic load;
  logic step;
  logic last_iter;

  // Reset gating keeps stall low while reset is held, even with start high.
  assign accept = (state_q == IDLE) & start & (alu_ctrl_t'(alu_ctrl) == ALU_MULT)
                & ~flush & ~reset;

`ifdef ALU_MULT_EARLY_TERM_EN
  logic mplier_last;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) | mplier_last;
`else
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  mult_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk           (clk),
    .reset         (reset),
    .load_i        (load),
    .step_i        (step),
    .op_a_i        (op_a),
    .op_b_i        (op_b),
    .acc_o         (acc)
`ifdef ALU_MULT_EARLY_TERM_EN
    ,
    .mplier_last_o (mplier_last)
`endif
  );

  // Next state and control outputs.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    stall   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          stall   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        stall = 1'b1;
        step  = ~flush;
        if (flush) begin
          state_d = IDLE;
        end else if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // stall stays low so the stage advances with the valid product.
        busy    = 1'b1;
        done    = ~flush;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The held result only updates on a completed (unflushed) DONE.
  always_comb begin
    result_d = result_q;
    if (done) begin
      result_d = acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // In DONE the accumulator is presented directly, so the product is visible
  // in the done cycle while result_q still holds the previous one.
  assign result_lo = done ? acc[WIDTH-1:0]       : result_q[WIDTH-1:0];
  assign result_hi = done ? acc[2*WIDTH-1:WIDTH] : result_q[2*WIDTH-1:WIDTH];

endmodule : alu_mult_sequencer

// File: tb/tb_alu_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_mult_sequencer
//
// Self-checking bench for alu_mult_sequencer (WIDTH = 32). A transaction-level
// model (countdown to the done cycle, product from plain multiplication) is
// compared against the DUT on every falling edge; directed sequences pin
// latencies and products with literal values. Honors ALU_MULT_EARLY_TERM_EN.
// -----------------------------------------------------------------------------
module tb_alu_mult_sequencer;

  localparam int W = 32;

`ifdef ALU_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;

  int checks;
  int errors;

  alu_mult_sequencer #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of RUN cycles for a multiplier value.
  function automatic int iters(input logic [W-1:0] b);
    int n;
    n = W;
    if (EARLY) begin
      n = 1;
      for (int i = 0; i < W; i++) begin
        if (b[i]) n = i + 1;
      end
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: m_wait = cycles left until the done cycle (-1 when idle).
  // ---------------------------------------------------------------------------
  int          m_wait;
  logic [63:0] m_prod;
  logic [63:0] m_res;

  initial begin
    m_wait = -1;
    m_prod = '0;
    m_res  = '0;
  end

  always @(negedge clk) begin
    logic        e_acc;
    logic        e_busy;
    logic        e_stall;
    logic        e_done;
    logic [63:0] e_res;
    if (reset) begin
      m_wait = -1;
      m_prod = '0;
      m_res  = '0;
    end
    e_acc   = (m_wait < 0) && start && (alu_ctrl == 3'b110) && !flush && !reset;
    e_busy  = (m_wait >= 0);
    e_stall = e_acc || (m_wait > 0);
    e_done  = (m_wait == 0) && !flush;
    e_res   = e_done ? m_prod : m_res;
    check("stall", 64'(stall), 64'(e_stall));
    check("busy",  64'(busy),  64'(e_busy));
    check("done",  64'(done),  64'(e_done));
    check("result", {result_hi, result_lo}, e_res);
    if (m_wait >= 0) begin
      if (flush) begin
        m_wait = -1;
      end else if (m_wait == 0) begin
        m_res  = m_prod;
        m_wait = -1;
      end else begin
        m_wait = m_wait - 1;
      end
    end else if (e_acc) begin
      m_prod = {32'd0, op_a} * {32'd0, op_b};
      m_wait = iters(op_b);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed multiply: upstream holds the instruction until done appears.
  // ---------------------------------------------------------------------------
  task automatic do_mult(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input logic [63:0] exp_prod);
    int  n;
    int  n_stall;
    bit  seen;
    @(posedge clk); #1;
    start    = 1'b1;
    alu_ctrl = 3'b110;
    op_a     = a;
    op_b     = b;
    flush    = 1'b0;
    n        = 0;
    n_stall  = 0;
    seen     = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (stall) n_stall++;
        n++;
      end
    end
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_stall_cycles"}, 64'(n_stall), 64'(exp_lat));
    check({name, "_stall_in_done"}, 64'(stall), 64'd0);
    check({name, "_product"}, {result_hi, result_lo}, exp_prod);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({name, "_held"}, {result_hi, result_lo}, exp_prod);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = 32'd1;
      2:       v = '1;
      3:       v = W'($urandom_range(0, 255));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int bad;
    logic [W-1:0] fb;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    alu_ctrl = 3'b000;
    op_a     = '0;
    op_b     = '0;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {result_hi, result_lo}, 64'd0);
    check("reset_flags", {61'd0, stall, busy, done}, 64'd0);
    #2 reset = 1'b0;

    // Basic product and full-scale product.
    do_mult("mul_7x6", 32'd7, 32'd6, EARLY ? 4 : 33, 64'd42);
    do_mult("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 64'hFFFF_FFFE_0000_0001);

    // Non-MULT code: the block must stay idle.
    @(posedge clk); #1;
    start    = 1'b1;
    alu_ctrl = 3'b000;
    op_a     = 32'd123;
    op_b     = 32'd456;
    bad      = 0;
    repeat (40) begin
      @(negedge clk);
      if (stall || busy || done) bad++;
    end
    check("add_idle", 64'(bad), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;

    // Flush at T+10: no done, previous product retained, stall low at T+11.
    fb = EARLY ? 32'h8000_0009 : 32'd9;
    @(posedge clk); #1;
    start    = 1'b1;
    alu_ctrl = 3'b110;
    op_a     = 32'd5;
    op_b     = fb;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("flush_no_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {62'd0, stall, busy}, 64'd0);
    check("flush_result_kept", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) bad++;
    end
    check("flush_never_done", 64'(bad), 64'd0);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk); #1;
    start    = 1'b1;
    alu_ctrl = 3'b110;
    op_a     = 32'd11;
    op_b     = 32'h8000_0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_reset_flags", {61'd0, stall, busy, done}, 64'd0);
    check("async_reset_result", {result_hi, result_lo}, 64'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    do_mult("mul_3x4", 32'd3, 32'd4, EARLY ? 4 : 33, 64'd12);

    // Zero / one multiplier: early exit when enabled.
    do_mult("mul_b0", 32'd77, 32'd0, EARLY ? 2 : 33, 64'd0);
    do_mult("mul_b1", 32'd100, 32'd1, EARLY ? 2 : 33, 64'd100);

    // Random traffic checked by the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start    = ($urandom_range(0, 3) != 0);
      alu_ctrl = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b110;
      flush    = ($urandom_range(0, 59) == 0);
      op_a     = pick();
      op_b     = pick();
    end
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_mult_sequencer

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
- Multi-cycle unsigned shift-add multiplier controller for the execute stage.
- Accepts an operation only when the ALU control code equals MULT (3'b110).
- Holds the pipeline with a stall while the multiply iterates, then presents a 2*WIDTH-bit product with a one-cycle done pulse.
- All other ALU codes pass untouched: the block stays idle and never stalls.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  execute-stage instruction valid this cycle.
- alu_ctrl  input  3  decoded ALU control code; only MULT (3'b110) is accepted.
- op_a  input  WIDTH  multiplicand, unsigned.
- op_b  input  WIDTH  multiplier, unsigned.
- flush  input  1  pipeline flush; aborts any operation in progress.
- stall  output  1  pipeline hold request.
- busy  output  1  high in RUN or DONE.
- done  output  1  one-cycle pulse; product valid.
- result_lo  output  WIDTH  low half of the product.
- result_hi  output  WIDTH  high half of the product.

Behaviour:
- Reset (async, active-high): state=IDLE. stall, busy, done, result_lo, result_hi, counter and internal registers all 0.
- accept = (state==IDLE) & start & (alu_ctrl==MULT) & ~flush.
- IDLE:
  - On accept: load mcand={WIDTH'0,op_a}, mplier=op_b, acc=0, cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per cycle:
  - If mplier[0]==1: acc += mcand, modulo 2^(2*WIDTH).
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - When cnt reaches WIDTH-1 in this cycle, go to DONE.
- DONE (exactly one cycle):
  - done=1; result_hi/result_lo drive acc; go to IDLE.
  - The result registers keep their value until the next DONE.
- stall timing:
  - Combinational: asserted in the accept cycle and in every RUN cycle; low in DONE, so the pipeline advances with a valid result.
  - Never asserted for non-MULT codes.
- Latency: accept cycle T → done at T+WIDTH+1 (T+33 at default). Throughput is one multiply per WIDTH+2 cycles.
- start while busy: ignored. The pipeline is stalled, so the upstream holds the same instruction, and it is not re-accepted after DONE because stall drops and the stage advances.
- flush:
  - In RUN or DONE: next state IDLE, done suppressed, result registers unchanged, stall low from the next cycle.
  - Same cycle as start in IDLE: flush wins, nothing accepted.
- reset mid-RUN: immediate return to the reset values; no done pulse.
- Operand zero: RUN still performs all WIDTH iterations unless the optional feature is enabled.

Optional Feature:
- Macro: ALU_MULT_EARLY_TERM_EN.
- Defined:
  - In RUN, if mplier (after the current shift) == 0, go to DONE immediately; the product is exact, since the remaining bits contribute 0.
  - Additionally, accept with op_b==0 goes IDLE→RUN for one cycle then DONE, so done arrives at T+2.
  - stall follows the state as normal.
- Undefined: fixed WIDTH-iteration latency; the early-exit comparator is absent.

Decomposition:
- Package alu_pkg:
  - typedef alu_ctrl_t (logic [2:0]).
  - Constants ALU_ADD=3'b000, ALU_XOR=3'b001, ALU_SUB=3'b010, ALU_SLT=3'b011, ALU_SLL=3'b100, ALU_SRL=3'b101, ALU_MULT=3'b110.
  - enum mult_state_t {IDLE, RUN, DONE}.
- Sub-module mult_shift_add_dp: acc/mcand/mplier registers plus the adder, controlled by load/step enables from the FSM in alu_mult_sequencer. All other logic stays in the top.

Test Plan:
- Reset then start=1, alu_ctrl=3'b110, op_a=7, op_b=6 → stall high 33 cycles, done at T+33, result_lo=42, result_hi=0, stall low in the done cycle.
- op_a=32'hFFFFFFFF, op_b=32'hFFFFFFFF → result_hi=32'hFFFFFFFE, result_lo=32'h00000001.
- start=1, alu_ctrl=3'b000 (ADD), any operands → stall, busy and done stay 0 for 40 cycles.
- Accept with 5×9, assert flush at T+10 → IDLE at T+11, no done pulse, result equals the previous product, stall low from T+11.
- Assert reset asynchronously mid-RUN (between clock edges) → all outputs 0 immediately. Then start with 3×4 → result_lo=12 at T+33.
- With ALU_MULT_EARLY_TERM_EN: op_b=0 → done at T+2, result 0. op_b=1, op_a=100 → done at T+2, result_lo=100. Without the macro, both cases give done at T+33.
